// File: rtl/switch_debounce_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | switch_debounce_pkg : shared defaults, types and width helper            |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
package switch_debounce_pkg;

  localparam int SW_WIDTH_DEFAULT     = 18;
  localparam int TICK_DIV_DEFAULT     = 50000;
  localparam int STABLE_TICKS_DEFAULT = 10;

  typedef logic [SW_WIDTH_DEFAULT-1:0] sw_vec_t;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/switch_debounce_chan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | switch_debounce_chan : one channel - 2-flop sync plus tick stability      |
// | filter with a registered change pulse.  Revision 1.0                      |
// +--------------------------------------------------------------------------+
module switch_debounce_chan
  import switch_debounce_pkg::*;
#(
  parameter int STABLE_TICKS = STABLE_TICKS_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw_raw,
  input  logic tick,
  output logic sw_clean,
  output logic sw_changed
);

  localparam int               CNT_W    = cnt_width(STABLE_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_changed;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_stable  <= 1'b0;
      r_changed <= 1'b0;
      r_count   <= '0;
    end else begin
      r_sync1   <= sw_raw;
      r_sync2   <= r_sync1;
      r_changed <= 1'b0;
      // Any agreement with the stable value restarts the qualification run.
      if (r_sync2 == r_stable) begin
        r_count <= '0;
      end else if (tick) begin
        if (r_count == CNT_LAST) begin
          r_stable  <= r_sync2;
          r_count   <= '0;
          r_changed <= 1'b1;
        end else begin
          r_count <= r_count + CNT_W'(1);
        end
      end
    end
  end

  assign sw_clean   = r_stable;
  assign sw_changed = r_changed;

endmodule
`default_nettype wire

// File: rtl/switch_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | switch_debounce : shared prescaler feeding WIDTH debounce channels.       |
// | Optional edge capture / irq under SWITCH_DEBOUNCE_EDGE_IRQ_EN. Rev 1.0    |
// +--------------------------------------------------------------------------+
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int WIDTH        = SW_WIDTH_DEFAULT,
  parameter int TICK_DIV     = TICK_DIV_DEFAULT,
  parameter int STABLE_TICKS = STABLE_TICKS_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_changed,
  output logic             sample_tick
`ifdef SWITCH_DEBOUNCE_EDGE_IRQ_EN
  ,
  input  logic [WIDTH-1:0] edge_clear,
  output logic [WIDTH-1:0] edge_capture,
  output logic             irq
`endif
);

  localparam int                 PRESC_W    = cnt_width(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0] r_presc;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else if (r_presc == PRESC_LAST) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PRESC_W'(1);
    end
  end

  assign sample_tick = reset_n && (r_presc == PRESC_LAST);

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
      switch_debounce_chan #(
        .STABLE_TICKS (STABLE_TICKS)
      ) u_chan (
        .clk        (clk),
        .reset_n    (reset_n),
        .sw_raw     (sw_raw[gi]),
        .tick       (sample_tick),
        .sw_clean   (sw_clean[gi]),
        .sw_changed (sw_changed[gi])
      );
    end
  endgenerate

`ifdef SWITCH_DEBOUNCE_EDGE_IRQ_EN
  // A new edge outranks a simultaneous clear so no event is lost.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      edge_capture <= '0;
      irq          <= 1'b0;
    end else begin
      edge_capture <= (edge_capture & ~edge_clear) | sw_changed;
      irq          <= |edge_capture;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_switch_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_switch_debounce : directed + random bench with a tick-arithmetic model |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_switch_debounce;

  localparam int W  = 18;
  localparam int TD = 4;
  localparam int ST = 3;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_clean;
  logic [W-1:0] sw_changed;
  logic         sample_tick;
`ifdef SWITCH_DEBOUNCE_EDGE_IRQ_EN
  logic [W-1:0] edge_clear;
  logic [W-1:0] edge_capture;
  logic         irq;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  logic [W-1:0] m_s1, m_s2, m_clean, m_chg, m_cap;
  logic         m_irq;
  int           last_agree [W];
  int           n_edge;

  always #5 clk = ~clk;

  switch_debounce #(
    .WIDTH        (W),
    .TICK_DIV     (TD),
    .STABLE_TICKS (ST)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sw_raw       (sw_raw),
    .sw_clean     (sw_clean),
    .sw_changed   (sw_changed),
    .sample_tick  (sample_tick)
`ifdef SWITCH_DEBOUNCE_EDGE_IRQ_EN
    ,
    .edge_clear   (edge_clear),
    .edge_capture (edge_capture),
    .irq          (irq)
`endif
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // A flip happens on a tick edge once STABLE ticks have elapsed since the
  // last cycle in which the synchronised input agreed with the clean value.
  task automatic model_edge();
    logic [W-1:0] old_s2, chg_old;
    logic         tick;
    chg_old = m_chg;
    if (!reset_n) begin
      m_s1 = '0; m_s2 = '0; m_clean = '0; m_chg = '0; m_cap = '0; m_irq = 1'b0;
      for (int i = 0; i < W; i++) last_agree[i] = -1;
      n_edge = 0;
      return;
    end
    old_s2 = m_s2;
    m_s2   = m_s1;
    m_s1   = sw_raw;
    m_chg  = '0;
    tick   = (n_edge % TD) == TD - 1;
    for (int i = 0; i < W; i++) begin
      if (old_s2[i] == m_clean[i]) begin
        last_agree[i] = n_edge;
      end else if (tick && ((n_edge + 1) / TD - (last_agree[i] + 1) / TD) == ST) begin
        m_clean[i]    = old_s2[i];
        m_chg[i]      = 1'b1;
        last_agree[i] = n_edge;
      end
    end
    n_edge++;
`ifdef SWITCH_DEBOUNCE_EDGE_IRQ_EN
    m_irq = |m_cap;
    m_cap = (m_cap & ~edge_clear) | chg_old;
`else
    m_irq = 1'b0;
    m_cap = chg_old;
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("sw_clean", sw_clean, m_clean);
    chk("sw_changed", sw_changed, m_chg);
    chk("sample_tick", W'(sample_tick), W'(reset_n && ((n_edge % TD) == TD - 1)));
`ifdef SWITCH_DEBOUNCE_EDGE_IRQ_EN
    chk("edge_capture", edge_capture, m_cap);
    chk("irq", W'(irq), W'(m_irq));
`endif
  endtask

  task automatic settle_zero();
    int n;
    sw_raw = '0;
    n = 0;
    do begin step(); n++; end while (sw_clean !== '0 && n < 40);
    chk("settle_zero", sw_clean, '0);
    repeat (3) step();
  endtask

  initial begin
    int n;
    int ticks;
    reset_n = 1'b0;
    sw_raw  = 18'h3FFFF;
`ifdef SWITCH_DEBOUNCE_EDGE_IRQ_EN
    edge_clear = '0;
`endif

    // Reset held for five cycles with all switches high
    repeat (5) step();
    chk("reset_clean", sw_clean, '0);

    // Release: tick appears on the fourth cycle (prescaler == 3)
    reset_n = 1'b1;
    sw_raw  = '0;
    step(); chk("tick_c1", W'(sample_tick), '0);
    step(); chk("tick_c2", W'(sample_tick), '0);
    step(); chk("tick_c3", W'(sample_tick), W'(1));
    repeat (4) step();

    // Clean edge on bit 0, bounded latency
    sw_raw[0] = 1'b1;
    n = 0;
    do begin step(); n++; end while (!sw_changed[0] && n < 20);
    chk("edge0_pulse", sw_changed, W'(1));
    chk("edge0_latency_ok", W'(n <= 3 + ST * TD), W'(1));
    step();
    chk("edge0_pulse_gone", sw_changed, '0);

    // Bounce on bit 5, then hold high
    for (int k = 0; k < 4; k++) begin
      sw_raw[5] = (k % 2 == 0);
      repeat (5) step();
    end
    sw_raw[5] = 1'b1;
    repeat (20) step();
    chk("bounce5_final", W'(sw_clean[5]), W'(1));

    // Simultaneous multi-bit flip
    settle_zero();
    sw_raw = 18'h2A5A5;
    n = 0;
    do begin step(); n++; end while (sw_changed === '0 && n < 30);
    chk("multi_changed", sw_changed, 18'h2A5A5);
    chk("multi_clean", sw_clean, 18'h2A5A5);

    // Reset in the middle of a qualification run
    settle_zero();
    sw_raw[3] = 1'b1;
    ticks = 0;
    n = 0;
    while (ticks < 2 && n < 30) begin
      step(); n++;
      if (sample_tick) ticks++;
    end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    repeat (20) step();
    chk("midreset_final", W'(sw_clean[3]), W'(1));

    // Random switch activity with occasional resets and clears
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 9) == 0) sw_raw = sw_raw ^ (W'($urandom) & W'($urandom));
      reset_n = ($urandom_range(0, 199) != 0);
`ifdef SWITCH_DEBOUNCE_EDGE_IRQ_EN
      edge_clear = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
`endif
      step();
    end
    reset_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
